dallanma_cozucu: RTL and testbench

Branch resolution unit on the execute side of the fetch/branch-prediction loop. Records every prediction issued at fetch in an in-order tracking queue. Compares each queue head with the actual outcome reported by execute, and produces the registered predictor-update bundle (valid, old instruction, old address, taken, target, mispredict). On a mispredict it also produces a one-cycle pipeline flush with the corrected fetch address.

---
 rtl/dallanma_cozucu.sv | 116 +++++++++++
 tb/tb_dallanma_cozucu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dallanma_cozucu.sv
// dallanma_cozucu: tracks fetch predictions in order and resolves them against execute outcomes.
// Define DALLANMA_SAYAC_EN to add saturating branch/mispredict counters.
module dallanma_cozucu #(
  parameter int DERINLIK   = 4,
  parameter int BUYRUK_BIT = 32
) (
  input  logic                  clk_g,
  input  logic                  rst_g,
  input  logic                  i_ongoru_gecerli,
  input  logic [BUYRUK_BIT-1:0] i_ongoru_buyruk,
  input  logic [BUYRUK_BIT-1:0] i_ongoru_adres,
  input  logic                  i_ongoru_atladi,
  input  logic [BUYRUK_BIT-1:0] i_ongoru_hedef,
  output logic                  o_kuyruk_dolu,
  input  logic                  i_coz_gecerli,
  input  logic [BUYRUK_BIT-1:0] i_coz_adres,
  input  logic                  i_coz_atladi,
  input  logic [BUYRUK_BIT-1:0] i_coz_hedef,
  output logic                  o_guncelle_gecerli,
  output logic [BUYRUK_BIT-1:0] o_eski_buyruk,
  output logic [BUYRUK_BIT-1:0] o_eski_buyruk_adresi,
  output logic                  o_buyruk_atladi,
  output logic [BUYRUK_BIT-1:0] o_atlanan_adres,
  output logic                  o_ongoru_yanlis,
  output logic                  o_temizle,
  output logic [BUYRUK_BIT-1:0] o_yeni_pc,
  output logic                  o_eslesme_hatasi
`ifdef DALLANMA_SAYAC_EN
  ,
  output logic [31:0]           o_dallanma_sayisi,
  output logic [31:0]           o_yanlis_sayisi
`endif
);
  localparam int AW = $clog2(DERINLIK);
  localparam logic [0:0] CALIS   = 1'b0;
  localparam logic [0:0] TEMIZLE = 1'b1;
  logic [BUYRUK_BIT-1:0] buyruk_m [DERINLIK];
  logic [BUYRUK_BIT-1:0] adres_m  [DERINLIK];
  logic [BUYRUK_BIT-1:0] hedef_m  [DERINLIK];
  logic                  atladi_m [DERINLIK];
  logic [AW:0] oku, yaz;
  logic [0:0] durum;
  logic bos, calis, coz_aktif, eslesir, yanlis, yanlis_coz, enq_ister, enq, hata;
  logic [BUYRUK_BIT-1:0] bas_buyruk, bas_adres, bas_hedef, duzeltilmis;
  logic bas_atladi;
  always_comb begin
    bos           = oku == yaz;
    o_kuyruk_dolu = (oku[AW-1:0] == yaz[AW-1:0]) && (oku[AW] != yaz[AW]);
    bas_buyruk    = buyruk_m[oku[AW-1:0]];
    bas_adres     = adres_m[oku[AW-1:0]];
    bas_hedef     = hedef_m[oku[AW-1:0]];
    bas_atladi    = atladi_m[oku[AW-1:0]];
    calis         = durum == CALIS;
    coz_aktif     = i_coz_gecerli && calis;
    eslesir       = coz_aktif && !bos && (i_coz_adres == bas_adres);
    yanlis        = (bas_atladi != i_coz_atladi) || (bas_atladi && i_coz_atladi && (bas_hedef != i_coz_hedef));
    yanlis_coz    = eslesir && yanlis;
    enq_ister     = i_ongoru_gecerli && calis && !yanlis_coz;
    enq           = enq_ister && !o_kuyruk_dolu;
    hata          = (enq_ister && o_kuyruk_dolu) || (coz_aktif && !eslesir);
    duzeltilmis   = i_coz_atladi ? i_coz_hedef
                  : bas_adres + (&bas_buyruk[1:0] ? BUYRUK_BIT'(4) : BUYRUK_BIT'(2));
  end
  always_ff @(posedge clk_g) begin
    if (enq) begin
      buyruk_m[yaz[AW-1:0]] <= i_ongoru_buyruk;
      adres_m[yaz[AW-1:0]]  <= i_ongoru_adres;
      hedef_m[yaz[AW-1:0]]  <= i_ongoru_hedef;
      atladi_m[yaz[AW-1:0]] <= i_ongoru_atladi;
    end
  end
  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      oku                  <= '0;
      yaz                  <= '0;
      durum                <= CALIS;
      o_guncelle_gecerli   <= 1'b0;
      o_eski_buyruk        <= '0;
      o_eski_buyruk_adresi <= '0;
      o_buyruk_atladi      <= 1'b0;
      o_atlanan_adres      <= '0;
      o_ongoru_yanlis      <= 1'b0;
      o_temizle            <= 1'b0;
      o_yeni_pc            <= '0;
      o_eslesme_hatasi     <= 1'b0;
    end else begin
      durum              <= yanlis_coz ? TEMIZLE : CALIS;
      o_guncelle_gecerli <= eslesir;
      o_temizle          <= yanlis_coz;
      o_eslesme_hatasi   <= o_eslesme_hatasi | hata;
      // a mispredict discards every younger entry along with the head
      oku <= yanlis_coz ? '0 : oku + (AW+1)'(eslesir);
      yaz <= yanlis_coz ? '0 : yaz + (AW+1)'(enq);
      if (eslesir) begin
        o_eski_buyruk        <= bas_buyruk;
        o_eski_buyruk_adresi <= bas_adres;
        o_buyruk_atladi      <= i_coz_atladi;
        o_atlanan_adres      <= i_coz_hedef;
        o_ongoru_yanlis      <= yanlis;
      end
      if (yanlis_coz) o_yeni_pc <= duzeltilmis;
    end
  end
`ifdef DALLANMA_SAYAC_EN
  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      o_dallanma_sayisi <= '0;
      o_yanlis_sayisi   <= '0;
    end else begin
      if (eslesir && !(&o_dallanma_sayisi)) o_dallanma_sayisi <= o_dallanma_sayisi + 32'd1;
      if (yanlis_coz && !(&o_yanlis_sayisi)) o_yanlis_sayisi <= o_yanlis_sayisi + 32'd1;
    end
  end
`else
`endif
endmodule

// File: tb/tb_dallanma_cozucu.sv
// tb_dallanma_cozucu: directed checks of the branch resolution unit.
module tb_dallanma_cozucu;
  logic clk_g = 1'b0;
  logic rst_g;
  logic og, oat, cg, cat;
  logic [31:0] obuy, oadr, ohed, cadr, ched;
  logic dolu, guncelle, atladi, yanlis, temizle, hata;
  logic [31:0] eski_buy, eski_adr, atlanan, yeni_pc;
`ifdef DALLANMA_SAYAC_EN
  logic [31:0] dallanma_sayisi, yanlis_sayisi;
`endif
  int hatalar = 0;
  int toplam = 0;
  always #5 clk_g = ~clk_g;
  dallanma_cozucu dut (
    .clk_g(clk_g), .rst_g(rst_g),
    .i_ongoru_gecerli(og), .i_ongoru_buyruk(obuy), .i_ongoru_adres(oadr),
    .i_ongoru_atladi(oat), .i_ongoru_hedef(ohed), .o_kuyruk_dolu(dolu),
    .i_coz_gecerli(cg), .i_coz_adres(cadr), .i_coz_atladi(cat), .i_coz_hedef(ched),
    .o_guncelle_gecerli(guncelle), .o_eski_buyruk(eski_buy), .o_eski_buyruk_adresi(eski_adr),
    .o_buyruk_atladi(atladi), .o_atlanan_adres(atlanan), .o_ongoru_yanlis(yanlis),
    .o_temizle(temizle), .o_yeni_pc(yeni_pc), .o_eslesme_hatasi(hata)
`ifdef DALLANMA_SAYAC_EN
    , .o_dallanma_sayisi(dallanma_sayisi), .o_yanlis_sayisi(yanlis_sayisi)
`endif
  );
  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    toplam++;
    if (gozlenen !== beklenen) begin
      hatalar++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", etiket, gozlenen, beklenen);
    end
  endtask
  task automatic tik;
    @(posedge clk_g);
    #1;
  endtask
  task automatic ongoru(input logic [31:0] a, input logic [31:0] b, input logic t, input logic [31:0] h);
    og = 1'b1; oadr = a; obuy = b; oat = t; ohed = h;
    tik;
    og = 1'b0;
  endtask
  task automatic coz(input logic [31:0] a, input logic t, input logic [31:0] h);
    cg = 1'b1; cadr = a; cat = t; ched = h;
    tik;
    cg = 1'b0;
  endtask
  task automatic ikisi(input logic [31:0] oa, input logic [31:0] ca);
    og = 1'b1; oadr = oa; obuy = 32'h13; oat = 1'b0; ohed = 32'h0;
    cg = 1'b1; cadr = ca; cat = 1'b0; ched = 32'h0;
    tik;
    og = 1'b0; cg = 1'b0;
  endtask
  initial begin
    og = 0; oat = 0; cg = 0; cat = 0; obuy = 0; oadr = 0; ohed = 0; cadr = 0; ched = 0;
    rst_g = 1'b1;
    tik; tik;
    kontrol("rst_guncelle", guncelle, 0);
    kontrol("rst_temizle", temizle, 0);
    kontrol("rst_hata", hata, 0);
    kontrol("rst_dolu", dolu, 0);
    kontrol("rst_yeni_pc", yeni_pc, 0);
    rst_g = 1'b0;
    tik;
    // correct not-taken
    ongoru(32'h100, 32'h00B50463, 1'b0, 32'h0);
    kontrol("nt_dolu", dolu, 0);
    coz(32'h100, 1'b0, 32'h0);
    kontrol("nt_guncelle", guncelle, 1);
    kontrol("nt_yanlis", yanlis, 0);
    kontrol("nt_temizle", temizle, 0);
    kontrol("nt_eski_buy", eski_buy, 32'h00B50463);
    kontrol("nt_eski_adr", eski_adr, 32'h100);
    tik;
    kontrol("nt_pulse", guncelle, 0);
    kontrol("nt_hold", eski_adr, 32'h100);
    // direction mispredict flushes younger entries
    ongoru(32'h200, 32'h13, 1'b0, 32'h0);
    ongoru(32'h204, 32'h13, 1'b0, 32'h0);
    ongoru(32'h208, 32'h13, 1'b0, 32'h0);
    coz(32'h200, 1'b1, 32'h300);
    kontrol("yon_yanlis", yanlis, 1);
    kontrol("yon_temizle", temizle, 1);
    kontrol("yon_yeni_pc", yeni_pc, 32'h300);
    kontrol("yon_guncelle", guncelle, 1);
    ongoru(32'h500, 32'h13, 1'b0, 32'h0);
    kontrol("yon_temizle_pulse", temizle, 0);
    kontrol("yon_hata", hata, 0);
    // compressed target mispredict; head must be 0x40 if the flush-cycle enqueue was ignored
    ongoru(32'h40, 32'h1, 1'b1, 32'h80);
    coz(32'h40, 1'b1, 32'h90);
    kontrol("hdf_guncelle", guncelle, 1);
    kontrol("hdf_yanlis", yanlis, 1);
    kontrol("hdf_yeni_pc", yeni_pc, 32'h90);
    kontrol("hdf_hata", hata, 0);
    tik;
    ongoru(32'h40, 32'h1, 1'b1, 32'h80);
    coz(32'h40, 1'b0, 32'h0);
    kontrol("c_nt_yeni_pc", yeni_pc, 32'h42);
    kontrol("c_nt_atladi", atladi, 0);
    tik;
    ongoru(32'h1000, 32'h63, 1'b1, 32'h2000);
    coz(32'h1000, 1'b0, 32'h0);
    kontrol("u_nt_yeni_pc", yeni_pc, 32'h1004);
    tik;
    ongoru(32'h60, 32'h3, 1'b1, 32'h80);
    coz(32'h60, 1'b1, 32'h80);
    kontrol("tk_yanlis", yanlis, 0);
    kontrol("tk_temizle", temizle, 0);
    kontrol("tk_atlanan", atlanan, 32'h80);
    kontrol("tk_atladi", atladi, 1);
    // full queue
    ongoru(32'hA0, 32'h13, 1'b0, 32'h0);
    ongoru(32'hA4, 32'h13, 1'b0, 32'h0);
    ongoru(32'hA8, 32'h13, 1'b0, 32'h0);
    kontrol("dolu3", dolu, 0);
    ongoru(32'hAC, 32'h13, 1'b0, 32'h0);
    kontrol("dolu4", dolu, 1);
    kontrol("dolu4_hata", hata, 0);
    ongoru(32'hB0, 32'h13, 1'b0, 32'h0);
    kontrol("dolu5_hata", hata, 1);
    kontrol("dolu5_dolu", dolu, 1);
    coz(32'hA0, 1'b0, 32'h0);
    kontrol("pop_dolu", dolu, 0);
    ikisi(32'hB4, 32'hA4);
    kontrol("ikisi_guncelle", guncelle, 1);
    kontrol("ikisi_adr", eski_adr, 32'hA4);
    kontrol("ikisi_dolu", dolu, 0);
    ongoru(32'hB8, 32'h13, 1'b0, 32'h0);
    kontrol("yeniden_dolu", dolu, 1);
    coz(32'hA8, 1'b0, 32'h0);
    coz(32'hAC, 1'b0, 32'h0);
    coz(32'hB4, 1'b0, 32'h0);
    kontrol("sira_b4", eski_adr, 32'hB4);
    kontrol("sira_guncelle", guncelle, 1);
    coz(32'hB8, 1'b0, 32'h0);
    kontrol("sira_b8", eski_adr, 32'hB8);
    // protocol errors
    coz(32'hC0, 1'b0, 32'h0);
    kontrol("bos_guncelle", guncelle, 0);
    kontrol("bos_hata", hata, 1);
    ongoru(32'hD0, 32'h13, 1'b0, 32'h0);
    coz(32'hD4, 1'b0, 32'h0);
    kontrol("adr_guncelle", guncelle, 0);
    kontrol("adr_hata", hata, 1);
    coz(32'hD0, 1'b0, 32'h0);
    kontrol("adr_sonra_guncelle", guncelle, 1);
    kontrol("hata_yapiskan", hata, 1);
    // async reset cancels a pending flush pulse
    ongoru(32'hE0, 32'h13, 1'b0, 32'h0);
    coz(32'hE0, 1'b1, 32'hF00);
    kontrol("ar_temizle_once", temizle, 1);
    rst_g = 1'b1;
    #1;
    kontrol("ar_temizle", temizle, 0);
    kontrol("ar_guncelle", guncelle, 0);
    kontrol("ar_hata", hata, 0);
    kontrol("ar_yeni_pc", yeni_pc, 0);
    tik;
    rst_g = 1'b0;
    tik;
`ifdef DALLANMA_SAYAC_EN
    ongoru(32'h10, 32'h13, 1'b0, 32'h0);
    ongoru(32'h14, 32'h13, 1'b0, 32'h0);
    coz(32'h10, 1'b0, 32'h0);
    coz(32'h14, 1'b0, 32'h0);
    ongoru(32'h18, 32'h13, 1'b0, 32'h0);
    coz(32'h18, 1'b1, 32'h50);
    tik;
    kontrol("sayac_dallanma", dallanma_sayisi, 3);
    kontrol("sayac_yanlis", yanlis_sayisi, 1);
    #2;
    rst_g = 1'b1;
    #1;
    kontrol("sayac_rst_dallanma", dallanma_sayisi, 0);
    kontrol("sayac_rst_yanlis", yanlis_sayisi, 0);
    tik;
    rst_g = 1'b0;
`endif
    $display("Result: errors=%0d of %0d checks", hatalar, toplam);
    $finish;
  end
endmodule
